// File: rtl/helios_stage_pkg.sv
// Stage encodings and address defaults shared by the vertex ports and the edge-link fabric.
package helios_stage_pkg;

   localparam int unsigned STAGE_WIDTH           = 3;
   localparam int unsigned DEFAULT_ADDRESS_WIDTH = 15;
   localparam int unsigned MAX_NEIGHBORS         = 8;

   typedef enum logic [STAGE_WIDTH-1:0] {
      STAGE_IDLE                = 3'd0,
      STAGE_MEASUREMENT_LOADING = 3'd1,
      STAGE_GROW_BOUNDARY       = 3'd2,
      STAGE_SPREAD_CLUSTER      = 3'd3,
      STAGE_SYNDROME_VALIDATION = 3'd4
   } stage_e;

   // Codes outside the defined set collapse to IDLE so they never trigger stage entry logic.
   function automatic stage_e decode_stage(input logic [STAGE_WIDTH-1:0] code);
      case (code)
         3'd1:    return STAGE_MEASUREMENT_LOADING;
         3'd2:    return STAGE_GROW_BOUNDARY;
         3'd3:    return STAGE_SPREAD_CLUSTER;
         3'd4:    return STAGE_SYNDROME_VALIDATION;
         default: return STAGE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/min_root_select.sv
// Masked minimum over the roots offered by grown links; a fixed 8-leaf compare tree
// with unused leaves tied invalid.
module min_root_select
   import helios_stage_pkg::*;
#(
   parameter int unsigned NEIGHBOR_COUNT = 4,
   parameter int unsigned ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH
) (
   input  logic [NEIGHBOR_COUNT-1:0]               i_grown,
   input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] i_roots,
   output logic [ADDRESS_WIDTH-1:0]                o_cand,
   output logic                                    o_valid
);

   if (NEIGHBOR_COUNT < 1 || NEIGHBOR_COUNT > MAX_NEIGHBORS) begin : g_bad_count
      $error("min_root_select: NEIGHBOR_COUNT must be 1..8");
   end

   logic [ADDRESS_WIDTH-1:0] w_val3 [8];
   logic                     w_vld3 [8];
   logic [ADDRESS_WIDTH-1:0] w_val2 [4];
   logic                     w_vld2 [4];
   logic [ADDRESS_WIDTH-1:0] w_val1 [2];
   logic                     w_vld1 [2];

   for (genvar g = 0; g < 8; g++) begin : g_leaf
      if (g < NEIGHBOR_COUNT) begin : g_used
         assign w_vld3[g] = i_grown[g];
         assign w_val3[g] = i_roots[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end else begin : g_unused
         assign w_vld3[g] = 1'b0;
         assign w_val3[g] = '0;
      end
   end

   // Left wins ties; an invalid side never wins against a valid one.
   for (genvar g = 0; g < 4; g++) begin : g_lvl2
      logic w_take_left;
      assign w_take_left = w_vld3[2*g] && (!w_vld3[2*g+1] || (w_val3[2*g] <= w_val3[2*g+1]));
      assign w_vld2[g]   = w_vld3[2*g] | w_vld3[2*g+1];
      assign w_val2[g]   = w_take_left ? w_val3[2*g] : w_val3[2*g+1];
   end

   for (genvar g = 0; g < 2; g++) begin : g_lvl1
      logic w_take_left;
      assign w_take_left = w_vld2[2*g] && (!w_vld2[2*g+1] || (w_val2[2*g] <= w_val2[2*g+1]));
      assign w_vld1[g]   = w_vld2[2*g] | w_vld2[2*g+1];
      assign w_val1[g]   = w_take_left ? w_val2[2*g] : w_val2[2*g+1];
   end

   logic w_root_left;
   assign w_root_left = w_vld1[0] && (!w_vld1[1] || (w_val1[0] <= w_val1[1]));
   assign o_valid     = w_vld1[0] | w_vld1[1];
   assign o_cand      = w_root_left ? w_val1[0] : w_val1[1];

endmodule

// File: rtl/vertex_link_port.sv
// Per-vertex endpoint: loads syndrome, pulses growth once per GROW entry, and
// merges roots / odd parity offered by fully-grown links during SPREAD.
module vertex_link_port
   import helios_stage_pkg::*;
#(
   parameter int unsigned NEIGHBOR_COUNT = 4,
   parameter int unsigned ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [STAGE_WIDTH-1:0]                  stage,
   input  logic [ADDRESS_WIDTH-1:0]                address,
   input  logic                                    is_defect_in,
   input  logic [NEIGHBOR_COUNT-1:0]               neighbor_fully_grown,
   input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] neighbor_old_root_in,
   input  logic [NEIGHBOR_COUNT-1:0]               neighbor_link_odd,
   output logic                                    increase,
   output logic [ADDRESS_WIDTH-1:0]                root,
   output logic                                    is_odd_cluster,
   output logic                                    busy
);

   stage_e                   w_stage;
   stage_e                   r_stage_d;
   logic                     w_entry;
   logic [ADDRESS_WIDTH-1:0] w_cand;
   logic                     w_cand_valid;
   logic                     w_grown_odd;
   logic                     w_root_lower;
   logic                     w_odd_rises;

   logic [ADDRESS_WIDTH-1:0] r_root;
   logic                     r_is_odd;
   logic                     r_increase;
   logic                     r_busy;

   min_root_select #(
      .NEIGHBOR_COUNT (NEIGHBOR_COUNT),
      .ADDRESS_WIDTH  (ADDRESS_WIDTH)
   ) u_min_root_select (
      .i_grown (neighbor_fully_grown),
      .i_roots (neighbor_old_root_in),
      .o_cand  (w_cand),
      .o_valid (w_cand_valid)
   );

   assign w_stage      = decode_stage(stage);
   assign w_entry      = (w_stage != r_stage_d);
   assign w_grown_odd  = |(neighbor_fully_grown & neighbor_link_odd);
   assign w_root_lower = w_cand_valid && (w_cand < r_root);
   assign w_odd_rises  = w_grown_odd && !r_is_odd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stage_d  <= STAGE_IDLE;
         r_root     <= '0;
         r_is_odd   <= 1'b0;
         r_increase <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_stage_d  <= w_stage;
         r_increase <= 1'b0;
         r_busy     <= 1'b0;
         case (w_stage)
            STAGE_MEASUREMENT_LOADING: begin
               r_root   <= address;
               r_is_odd <= is_defect_in;
            end
            STAGE_GROW_BOUNDARY: begin
               if (w_entry) r_increase <= r_is_odd;
            end
            STAGE_SPREAD_CLUSTER: begin
               // w_grown_odd is zero when no link is grown, so parity needs no extra gating.
               if (w_root_lower) r_root <= w_cand;
               r_is_odd <= r_is_odd | w_grown_odd;
               r_busy   <= w_root_lower | w_odd_rises;
            end
            default: ;
         endcase
      end
   end

   assign increase       = r_increase;
   assign root           = r_root;
   assign is_odd_cluster = r_is_odd;
   assign busy           = r_busy;

endmodule

// File: tb/tb_vertex_link_port.sv
// Directed plus randomized checks of vertex_link_port against a stage-rule reference model.
module tb_vertex_link_port;

   localparam int N = 4;
   localparam int W = 15;
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_GROW = 3'd2,
                          S_SPREAD = 3'd3, S_VALID = 3'd4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [2:0]     stage = S_IDLE;
   logic [W-1:0]   address = '0;
   logic           is_defect_in = 1'b0;
   logic [N-1:0]   grown = '0;
   logic [N-1:0]   link_odd = '0;
   logic [W-1:0]   nroot [N];
   logic [N*W-1:0] nroot_bus;
   logic           increase;
   logic [W-1:0]   root;
   logic           is_odd_cluster;
   logic           busy;

   logic [W-1:0]   m_root = '0;
   logic           m_odd = 1'b0, m_inc = 1'b0, m_busy = 1'b0;
   logic [2:0]     m_prev = S_IDLE;
   int             n_tests = 0;
   int             n_fail = 0;
   int             pulses = 0;

   always #5 clk = ~clk;

   always_comb begin
      nroot_bus = '0;
      for (int i = 0; i < N; i++) nroot_bus[i*W +: W] = nroot[i];
   end

   vertex_link_port #(
      .NEIGHBOR_COUNT (N),
      .ADDRESS_WIDTH  (W)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .stage                (stage),
      .address              (address),
      .is_defect_in         (is_defect_in),
      .neighbor_fully_grown (grown),
      .neighbor_old_root_in (nroot_bus),
      .neighbor_link_odd    (link_odd),
      .increase             (increase),
      .root                 (root),
      .is_odd_cluster       (is_odd_cluster),
      .busy                 (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".root"}, 32'(root), 32'(m_root));
      check({tag, ".odd"}, 32'(is_odd_cluster), 32'(m_odd));
      check({tag, ".inc"}, 32'(increase), 32'(m_inc));
      check({tag, ".busy"}, 32'(busy), 32'(m_busy));
   endtask

   task automatic model_clear();
      m_root = '0; m_odd = 1'b0; m_inc = 1'b0; m_busy = 1'b0; m_prev = S_IDLE;
   endtask

   // Applies one clock of the stage rules to the model using the inputs present at the edge.
   task automatic model_edge();
      logic [2:0]   eff;
      logic [W-1:0] offered [$];
      logic [W-1:0] cand, new_root;
      logic         new_odd;
      if (!reset) begin
         model_clear();
         return;
      end
      eff    = (stage <= S_VALID) ? stage : S_IDLE;
      m_inc  = (eff == S_GROW && eff != m_prev) ? m_odd : 1'b0;
      m_busy = 1'b0;
      if (eff == S_LOAD) begin
         m_root = address;
         m_odd  = is_defect_in;
      end else if (eff == S_SPREAD) begin
         for (int i = 0; i < N; i++) if (grown[i]) offered.push_back(nroot[i]);
         if (offered.size() > 0) begin
            cand = offered[0];
            foreach (offered[k]) if (offered[k] < cand) cand = offered[k];
            new_root = (cand < m_root) ? cand : m_root;
            new_odd  = m_odd | (|(grown & link_odd));
            m_busy   = (new_root != m_root) || (new_odd != m_odd);
            m_root   = new_root;
            m_odd    = new_odd;
         end
      end
      m_prev = eff;
   endtask

   task automatic step(input string tag, input logic [2:0] st, input logic def,
                       input logic [N-1:0] gr, input logic [N-1:0] lo,
                       input logic [W-1:0] r0, input logic [W-1:0] r1,
                       input logic [W-1:0] r2, input logic [W-1:0] r3);
      @(negedge clk);
      stage = st; is_defect_in = def; grown = gr; link_odd = lo;
      nroot[0] = r0; nroot[1] = r1; nroot[2] = r2; nroot[3] = r3;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      if (increase === 1'b1) pulses++;
   endtask

   task automatic hold(input string tag, input int n);
      for (int i = 0; i < n; i++)
         step(tag, stage, is_defect_in, grown, link_odd, nroot[0], nroot[1], nroot[2], nroot[3]);
   endtask

   task automatic async_reset_assert(input string tag);
      #2 reset = 1'b0;
      model_clear();
      #1 check_all(tag);
   endtask

   initial begin
      for (int i = 0; i < N; i++) nroot[i] = '0;
      #1 reset = 1'b0;
      #1;
      check("reset.root", 32'(root), 32'h0);
      check("reset.odd", 32'(is_odd_cluster), 32'h0);
      check("reset.inc", 32'(increase), 32'h0);
      check("reset.busy", 32'(busy), 32'h0);
      step("reset_hold", S_GROW, 1'b1, '0, '0, 0, 0, 0, 0);
      reset = 1'b1;

      // Load an odd vertex, then hold GROW: exactly one pulse, one cycle after entry.
      address = 15'h0012;
      step("load", S_LOAD, 1'b1, '0, '0, 0, 0, 0, 0);
      hold("load", 1);
      check("load.root_const", 32'(root), 32'h12);
      check("load.odd_const", 32'(is_odd_cluster), 32'h1);
      pulses = 0;
      step("grow_entry", S_GROW, 1'b0, '0, '0, 0, 0, 0, 0);
      check("grow.first_cycle_pulse", 32'(increase), 32'h1);
      hold("grow_hold", 4);
      check("grow.pulse_count", 32'(pulses), 32'd1);

      // Even vertex never pulses; odd re-entry after IDLE pulses once more.
      step("even_load", S_LOAD, 1'b0, '0, '0, 0, 0, 0, 0);
      pulses = 0;
      step("even_grow", S_GROW, 1'b0, '0, '0, 0, 0, 0, 0);
      hold("even_grow", 3);
      check("even.pulse_count", 32'(pulses), 32'd0);
      step("odd_load", S_LOAD, 1'b1, '0, '0, 0, 0, 0, 0);
      step("idle", S_IDLE, 1'b0, '0, '0, 0, 0, 0, 0);
      pulses = 0;
      step("regrow", S_GROW, 1'b0, '0, '0, 0, 0, 0, 0);
      hold("regrow", 2);
      step("regrow_idle", S_IDLE, 1'b0, '0, '0, 0, 0, 0, 0);
      step("regrow2", S_GROW, 1'b0, '0, '0, 0, 0, 0, 0);
      check("regrow.pulse_count", 32'(pulses), 32'd2);

      // Spread minimum: link 0 (0x05) is not grown, so 0x08 wins.
      address = 15'h0020;
      step("spread_load", S_LOAD, 1'b0, '0, '0, 0, 0, 0, 0);
      step("spread_min", S_SPREAD, 1'b0, 4'b0110, 4'b0000, 15'h05, 15'h10, 15'h08, 15'h30);
      check("spread.root_const", 32'(root), 32'h08);
      check("spread.busy_const", 32'(busy), 32'h1);
      hold("spread_settled", 1);
      check("spread.busy_settled", 32'(busy), 32'h0);

      // Odd propagation over an equal root, then tie and none-grown.
      address = 15'h0040;
      step("odd_load2", S_LOAD, 1'b0, '0, '0, 0, 0, 0, 0);
      step("odd_prop", S_SPREAD, 1'b0, 4'b0001, 4'b0001, 15'h40, 15'h0, 15'h0, 15'h0);
      check("odd_prop.odd_const", 32'(is_odd_cluster), 32'h1);
      check("odd_prop.busy_const", 32'(busy), 32'h1);
      hold("odd_prop_settled", 1);
      step("tie", S_SPREAD, 1'b0, 4'b1001, 4'b0000, 15'h40, 15'h1, 15'h2, 15'h40);
      check("tie.busy_const", 32'(busy), 32'h0);
      step("none_grown", S_SPREAD, 1'b0, 4'b0000, 4'b1111, 15'h1, 15'h2, 15'h3, 15'h4);
      check("none_grown.root_const", 32'(root), 32'h40);
      step("full_width", S_SPREAD, 1'b0, 4'b1111, 4'b0000, 15'h7FFF, 15'h7FFE, 15'h7FFF, 15'h41);
      step("spread_exit", S_VALID, 1'b0, 4'b1111, 4'b1111, 15'h0, 15'h0, 15'h0, 15'h0);

      // Async reset mid-SPREAD, then reload odd and grow once.
      address = 15'h0033;
      step("pre_rst_load", S_LOAD, 1'b0, '0, '0, 0, 0, 0, 0);
      step("pre_rst_spread", S_SPREAD, 1'b0, 4'b0010, 4'b0010, 15'h0, 15'h11, 15'h0, 15'h0);
      async_reset_assert("async_rst");
      check("async_rst.root_const", 32'(root), 32'h0);
      step("rst_held_grow", S_GROW, 1'b1, '0, '0, 0, 0, 0, 0);
      reset = 1'b1;
      step("post_rst_load", S_LOAD, 1'b1, '0, '0, 0, 0, 0, 0);
      pulses = 0;
      step("post_rst_grow", S_GROW, 1'b0, '0, '0, 0, 0, 0, 0);
      hold("post_rst_grow", 3);
      check("post_rst.pulse_count", 32'(pulses), 32'd1);

      // Randomized stage sequences with small root ranges so ties are frequent.
      for (int k = 0; k < 400; k++) begin
         logic [2:0]   st;
         int unsigned  pick;
         logic [W-1:0] rr [N];
         pick = $urandom_range(0, 10);
         st   = (pick > 7) ? S_SPREAD : 3'(pick);
         if ($urandom_range(0, 7) == 0)
            address = ($urandom_range(0, 3) == 0) ? 15'h7FFF : W'($urandom_range(0, 63));
         for (int i = 0; i < N; i++)
            rr[i] = ($urandom_range(0, 15) == 0) ? 15'h7FFF : W'($urandom_range(0, 63));
         if (k % 97 == 50) begin
            async_reset_assert("rand_rst");
            step("rand_rst_held", st, 1'($urandom), N'($urandom), N'($urandom),
                 rr[0], rr[1], rr[2], rr[3]);
            reset = 1'b1;
         end else begin
            step("rand", st, 1'($urandom), N'($urandom), N'($urandom),
                 rr[0], rr[1], rr[2], rr[3]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
